// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and PC arithmetic constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam logic [31:0] INSTR_BYTES   = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear; increments one edge after inc.
// No backpressure: inc is a single-cycle pulse, ignored once the count reaches all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: start-up hold, sequential fetch, branch/jump redirect, load-use stall, halt.
// Controls are combinational from state; redirects land in the PC one edge later; stalls hold PC and IF/ID.
module pc_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          START_WAIT = 1,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [31:0]      jmp_target,
    input  logic             load_use_stall,
    input  logic             halt,
    output logic [31:0]      npc,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             running,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [3:0] WAIT_LAST = 4'(START_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_INIT;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        npc        = pc;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        running    = 1'b0;
        redirect   = 1'b0;
        unique case (state)
            S_INIT: begin
                npc        = RESET_PC;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                running = 1'b1;
                // A taken branch squashes whatever sits in ID, so it outranks stall/halt/jump.
                if (br_taken) begin
                    npc        = br_target & PC_ALIGN_MASK;
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    redirect   = 1'b1;
                end else if (load_use_stall) begin
                    idex_flush = 1'b1;
                end else if (halt) begin
                    ifid_flush = 1'b1;
                    state_nxt  = S_HALT;
                end else if (jmp) begin
                    npc        = jmp_target & PC_ALIGN_MASK;
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    redirect   = 1'b1;
                end else begin
                    npc     = pc + INSTR_BYTES;
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end
            S_HALT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect),
        .cnt (redirect_cnt)
    );

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: inputs change on the falling edge, outputs are checked 1ns later.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        load_use_stall = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] npc;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        running;
    logic [15:0] redirect_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.RESET_PC(32'h0000_0000), .START_WAIT(1), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jmp            (jmp),
        .jmp_target     (jmp_target),
        .load_use_stall (load_use_stall),
        .halt           (halt),
        .npc            (npc),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .running        (running),
        .redirect_cnt   (redirect_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control word packed as {pc_we, ifid_we, ifid_flush, idex_flush, running}.
    function automatic logic [31:0] ctl();
        return {27'd0, pc_we, ifid_we, ifid_flush, idex_flush, running};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        br_taken = 0; jmp = 0; load_use_stall = 0; halt = 0;
    endtask

    initial begin
        // Reset held: INIT outputs.
        cyc(); #1;
        chk("init_npc", npc, 32'h0);
        chk("init_ctl", ctl(), 32'b01110);
        chk("init_cnt", {16'd0, redirect_cnt}, 32'd0);

        // Release: one held cycle, then RUN fetches sequentially.
        cyc(); rst = 1; br_taken = 1; br_target = 32'h500; #1;
        chk("hold_ctl", ctl(), 32'b01110);
        cyc(); idle(); pc = 32'h0; #1;
        chk("run_ctl", ctl(), 32'b11001);
        chk("run_npc", npc, 32'h4);
        chk("hold_br_ignored_cnt", {16'd0, redirect_cnt}, 32'd0);

        // Branch overrides stall and jump in the same cycle.
        cyc(); pc = 32'h40; br_taken = 1; br_target = 32'h103;
        load_use_stall = 1; jmp = 1; jmp_target = 32'h200; #1;
        chk("br_npc", npc, 32'h100);
        chk("br_ctl", ctl(), 32'b11111);
        cyc(); idle(); pc = 32'h100; #1;
        chk("br_cnt", {16'd0, redirect_cnt}, 32'd1);
        chk("after_br_npc", npc, 32'h104);

        // Two stalled cycles hold the jump, third cycle takes it.
        cyc(); load_use_stall = 1; jmp = 1; jmp_target = 32'h200; pc = 32'h108; #1;
        chk("stall1_ctl", ctl(), 32'b00011);
        cyc(); #1;
        chk("stall2_ctl", ctl(), 32'b00011);
        chk("stall2_cnt", {16'd0, redirect_cnt}, 32'd1);
        cyc(); load_use_stall = 0; #1;
        chk("jmp_npc", npc, 32'h200);
        chk("jmp_ctl", ctl(), 32'b11101);
        cyc(); idle(); pc = 32'h200; #1;
        chk("jmp_cnt", {16'd0, redirect_cnt}, 32'd2);

        // PC wrap and target alignment.
        cyc(); pc = 32'hFFFF_FFFC; #1;
        chk("wrap_npc", npc, 32'h0);
        cyc(); jmp = 1; jmp_target = 32'h0000_1237; #1;
        chk("align_npc", npc, 32'h1234);

        // Halt and branch together: branch wins, stays in RUN.
        cyc(); idle(); halt = 1; br_taken = 1; br_target = 32'h80; #1;
        chk("hb_npc", npc, 32'h80);
        chk("hb_ctl", ctl(), 32'b11111);
        cyc(); idle(); pc = 32'h80; #1;
        chk("hb_running", {31'd0, running}, 32'd1);
        chk("hb_cnt", {16'd0, redirect_cnt}, 32'd4);

        // Drive the redirect counter into saturation.
        jmp = 1; jmp_target = 32'h300;
        repeat (65531) cyc();
        #1;
        chk("sat_reach", {16'd0, redirect_cnt}, 32'h0000_FFFF);
        cyc(); #1;
        chk("sat_hold", {16'd0, redirect_cnt}, 32'h0000_FFFF);

        // Halt: ID stalls this cycle, HALT ignores inputs afterwards.
        cyc(); idle(); halt = 1; pc = 32'h50; #1;
        chk("halt_ctl", ctl(), 32'b00101);
        cyc(); idle(); br_taken = 1; br_target = 32'h700; jmp = 1; #1;
        chk("halted_ctl", ctl(), 32'b00110);
        chk("halted_npc", npc, 32'h50);
        cyc(); #1;
        chk("halted_stay", ctl(), 32'b00110);

        // Asynchronous reset mid-HALT returns to INIT at once.
        rst = 0; #1;
        chk("rst_ctl", ctl(), 32'b01110);
        chk("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
        chk("rst_npc", npc, 32'h0);
        cyc(); idle(); rst = 1; pc = 32'h0; #1;
        chk("rehold_ctl", ctl(), 32'b01110);
        cyc(); #1;
        chk("rerun_ctl", ctl(), 32'b11001);
        chk("rerun_npc", npc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Next-PC sequencer for the 5-stage pipeline. It sits beside the PC register and drives that register's write enable and next value.
- It owns the post-reset start-up hold, sequential fetch, branch and jump redirects, load-use stalls and halt.
- It also produces the IF/ID write-enable and flush controls, plus IF/ID and ID/EX bubble controls.

Parameters:
- RESET_PC, 32'h0000_0000, value presented on npc during INIT; the PC register resets to the same value.
- START_WAIT, 1, number of cycles after reset release during which the PC is held (range 1..15).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc  in  32  current PC register value (IF stage).
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  32  EX-stage branch target.
- jmp  in  1  ID-stage unconditional jump.
- jmp_target  in  32  ID-stage jump target.
- load_use_stall  in  1  hazard unit load-use detection.
- halt  in  1  ID-stage halt instruction decoded.
- npc  out  32  next PC value for the PC register.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  IF/ID register clears to a bubble on the next edge.
- idex_flush  out  1  ID/EX register clears to a bubble on the next edge.
- running  out  1  high only in RUN.
- redirect_cnt  out  CNT_W  count of taken redirects (branch plus jump), saturating.

Behaviour:
- Clock and reset: single clock clk; rst asynchronous active-low. While rst=0 the block is in INIT, wait counter=0, redirect_cnt=0.
- Control outputs are combinational from state and inputs. State, wait counter and redirect_cnt are registered.
- States: INIT, RUN, HALT. Two-bit state encoding.
- INIT:
  - npc=RESET_PC, pc_we=0, ifid_we=1, ifid_flush=1, idex_flush=1, running=0.
  - Wait counter increments each cycle; on the cycle the counter equals START_WAIT-1 the state moves to RUN.
  - With START_WAIT=1, exactly one held cycle follows reset release.
- RUN: fixed priority, evaluated every cycle.
  1. br_taken: npc=br_target & ~3, pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1; redirect_cnt+1. Overrides stall, jmp and halt, because the ID instruction is wrong-path.
  2. load_use_stall: pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1. A jmp or halt in ID is held and re-evaluated next cycle.
  3. halt: pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=0; next state HALT.
  4. jmp: npc=jmp_target & ~3, pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=0; redirect_cnt+1.
  5. Otherwise: npc=pc+4, pc_we=1, ifid_we=1, both flushes 0.
- HALT:
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, npc=pc, running=0.
  - Inputs are ignored; exit only via rst.
  - Older instructions still in EX/MEM/WB drain naturally.
- Arithmetic and width rules:
  - pc+4 wraps modulo 2^32; 32'hFFFF_FFFC maps to 32'h0000_0000.
  - Targets have bits [1:0] forced to 0.
  - redirect_cnt saturates at all-ones and never wraps.
- Reset asserted mid-operation (any state): immediate return to INIT with INIT output values, counters cleared. No pending redirect survives.
- Latency: a redirect is visible at the PC register output one edge after br_taken or jmp is sampled. Branch penalty is 2 bubbles; jump penalty is 1 bubble.

Decomposition:
- Shared package pipe_pkg: state encoding constants (S_INIT, S_RUN, S_HALT), INSTR_BYTES=4, PC_ALIGN_MASK=32'hFFFF_FFFC.
- One natural sub-module: sat_counter, a parameterised CNT_W saturating incrementer with async active-low clear, used for redirect_cnt.
- The start-up wait counter stays inline.

Test Plan:
- Reset release, START_WAIT=1, pc=0 → 1 cycle with pc_we=0 and ifid_flush=1; then running=1, npc=32'h4, pc_we=1.
- RUN, pc=32'h40, br_taken=1, br_target=32'h103, load_use_stall=1, jmp=1 in the same cycle → npc=32'h100, pc_we=1, ifid_flush=1, idex_flush=1, redirect_cnt increments by 1 (not 2).
- load_use_stall=1 for 2 cycles with jmp=1, jmp_target=32'h200 → 2 cycles with pc_we=0, ifid_we=0, idex_flush=1; third cycle npc=32'h200, ifid_flush=1.
- pc=32'hFFFF_FFFC, no events → npc=32'h0; redirect_cnt at 16'hFFFF plus a jmp → stays 16'hFFFF.
- halt=1 in RUN → next cycle running=0, pc_we=0; later br_taken=1 is ignored; rst pulse low mid-HALT → INIT immediately, redirect_cnt=0.
- halt=1 and br_taken=1 in the same cycle → redirect taken, state stays RUN.
